demux2n_stream: RTL and testbench

Registered 1-to-2 stream demultiplexer with valid/ready handshaking: the receive-side counterpart of the `mux2N` 2:1 selector. It takes one N-bit input stream and routes each accepted beat to lane 0, lane 1, alternately to each lane, or to both lanes at once, under control of a 2-bit select. Each lane has a one-entry output register with independent backpressure and a wrapping beat counter. The block sits where a single combined bus fans back out to two consumers.

---
 rtl/demux2n_stream_if.sv | 30 +++
 rtl/demux2n_stream.sv | 87 ++++++++
 tb/tb_demux2n_stream.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/demux2n_stream_if.sv
// Stream bus for demux2n_stream: one upstream valid/ready input and two downstream lanes.
// The master modport is the upstream producer plus the lane consumers. The slave modport is the demux.
interface demux2n_stream_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned CNT_W = 8;

    logic [1:0]       s;
    logic [N-1:0]     d;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     y0;
    logic             y0_valid;
    logic             y0_ready;
    logic [N-1:0]     y1;
    logic             y1_valid;
    logic             y1_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  s, d, in_valid, y0_ready, y1_ready,
        output in_ready, y0, y0_valid, y1, y1_valid, cnt0, cnt1
    );

    modport master (
        output s, d, in_valid, y0_ready, y1_ready,
        input  in_ready, y0, y0_valid, y1, y1_valid, cnt0, cnt1
    );
endinterface

// File: rtl/demux2n_stream.sv
// Registered 1-to-2 stream demultiplexer. Each beat goes to lane 0, lane 1, alternating lanes, or both lanes.
// Each lane has a one-entry output register with its own backpressure and a wrapping beat counter.
module demux2n_stream #(
    parameter int unsigned N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    demux2n_stream_if.slave   bus
);
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] SEL_LANE0 = 2'b00;
    localparam logic [1:0] SEL_LANE1 = 2'b01;
    localparam logic [1:0] SEL_ALT   = 2'b10;
    localparam logic [1:0] SEL_BCAST = 2'b11;

    logic [N-1:0]     y0_q, y0_d, y1_q, y1_d;
    logic             y0_valid_q, y0_valid_d, y1_valid_q, y1_valid_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             alt_q, alt_d;

    logic free0_c, free1_c, tgt0_c, tgt1_c, in_ready_c, accept_c;

    // Target set and readiness; in_valid is deliberately kept out of in_ready
    always_comb begin
        free0_c    = !y0_valid_q || bus.y0_ready;
        free1_c    = !y1_valid_q || bus.y1_ready;
        tgt0_c     = (bus.s == SEL_LANE0) || (bus.s == SEL_BCAST) || ((bus.s == SEL_ALT) && !alt_q);
        tgt1_c     = (bus.s == SEL_LANE1) || (bus.s == SEL_BCAST) || ((bus.s == SEL_ALT) && alt_q);
        in_ready_c = (!tgt0_c || free0_c) && (!tgt1_c || free1_c);
        accept_c   = bus.in_valid && in_ready_c;
    end

    // Next state: drain first, then a load on the same cycle overrides the drain
    always_comb begin
        y0_d       = y0_q;
        y1_d       = y1_q;
        y0_valid_d = y0_valid_q;
        y1_valid_d = y1_valid_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        alt_d      = alt_q;

        if (y0_valid_q && bus.y0_ready) y0_valid_d = 1'b0;
        if (y1_valid_q && bus.y1_ready) y1_valid_d = 1'b0;

        if (accept_c && tgt0_c) begin
            y0_d       = bus.d;
            y0_valid_d = 1'b1;
            cnt0_d     = CNT_W'(cnt0_q + 1'b1);
        end
        if (accept_c && tgt1_c) begin
            y1_d       = bus.d;
            y1_valid_d = 1'b1;
            cnt1_d     = CNT_W'(cnt1_q + 1'b1);
        end
        if (accept_c && (bus.s == SEL_ALT)) alt_d = !alt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_q       <= '0;
            y1_q       <= '0;
            y0_valid_q <= 1'b0;
            y1_valid_q <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            alt_q      <= 1'b0;
        end else begin
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            y0_valid_q <= y0_valid_d;
            y1_valid_q <= y1_valid_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            alt_q      <= alt_d;
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.y0       = y0_q;
    assign bus.y0_valid = y0_valid_q;
    assign bus.y1       = y1_q;
    assign bus.y1_valid = y1_valid_q;
    assign bus.cnt0     = cnt0_q;
    assign bus.cnt1     = cnt1_q;
endmodule

// File: tb/tb_demux2n_stream.sv
// Directed bench for demux2n_stream: a cycle-by-cycle vector table, then hand-written counter-wrap and async-reset sequences.
module tb_demux2n_stream;
    localparam int unsigned N     = 8;
    localparam int unsigned NVEC  = 20;

    typedef struct {
        logic [1:0] s;
        logic [7:0] d;
        logic       v, r0, r1;
        logic       ir;
        logic [7:0] y0;
        logic       y0v;
        logic [7:0] y1;
        logic       y1v;
        logic [7:0] c0, c1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [NVEC];

    demux2n_stream_if #(.N(N)) bus ();

    demux2n_stream #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] s, input logic [7:0] d, input logic v,
                                input logic r0, input logic r1, input logic ir,
                                input logic [7:0] y0, input logic y0v,
                                input logic [7:0] y1, input logic y1v,
                                input logic [7:0] c0, input logic [7:0] c1);
        vec_t t;
        t.s = s; t.d = d; t.v = v; t.r0 = r0; t.r1 = r1; t.ir = ir;
        t.y0 = y0; t.y0v = y0v; t.y1 = y1; t.y1v = y1v; t.c0 = c0; t.c1 = c1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] s, input logic [7:0] d, input logic v,
                         input logic r0, input logic r1);
        bus.s = s; bus.d = d; bus.in_valid = v; bus.y0_ready = r0; bus.y1_ready = r1;
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] y0, input logic y0v,
                            input logic [7:0] y1, input logic y1v,
                            input logic [7:0] c0, input logic [7:0] c1);
        chk({tag, ".y0"},       32'(bus.y0),       32'(y0));
        chk({tag, ".y0_valid"}, 32'(bus.y0_valid), 32'(y0v));
        chk({tag, ".y1"},       32'(bus.y1),       32'(y1));
        chk({tag, ".y1_valid"}, 32'(bus.y1_valid), 32'(y1v));
        chk({tag, ".cnt0"},     32'(bus.cnt0),     32'(c0));
        chk({tag, ".cnt1"},     32'(bus.cnt1),     32'(c1));
    endtask

    initial begin
        //             s      d     v     r0    r1    ir  | y0    y0v   y1    y1v   c0    c1
        // lane 0 routing, then drain
        vecs[0]  = mk(2'd0, 8'd5,   1'b1, 1'b1, 1'b1, 1'b1, 8'd5,   1'b1, 8'd0,   1'b0, 8'd1, 8'd0);
        vecs[1]  = mk(2'd0, 8'd0,   1'b0, 1'b1, 1'b1, 1'b1, 8'd5,   1'b0, 8'd0,   1'b0, 8'd1, 8'd0);
        // lane 1 routing
        vecs[2]  = mk(2'd1, 8'd10,  1'b1, 1'b1, 1'b1, 1'b1, 8'd5,   1'b0, 8'd10,  1'b1, 8'd1, 8'd1);
        vecs[3]  = mk(2'd1, 8'd0,   1'b0, 1'b1, 1'b1, 1'b1, 8'd5,   1'b0, 8'd10,  1'b0, 8'd1, 8'd1);
        // backpressure on lane 0, held beat re-steered to lane 1, then drain
        vecs[4]  = mk(2'd0, 8'd255, 1'b1, 1'b0, 1'b1, 1'b1, 8'd255, 1'b1, 8'd10,  1'b0, 8'd2, 8'd1);
        vecs[5]  = mk(2'd0, 8'd127, 1'b1, 1'b0, 1'b1, 1'b0, 8'd255, 1'b1, 8'd10,  1'b0, 8'd2, 8'd1);
        vecs[6]  = mk(2'd1, 8'd127, 1'b1, 1'b0, 1'b1, 1'b1, 8'd255, 1'b1, 8'd127, 1'b1, 8'd2, 8'd2);
        vecs[7]  = mk(2'd1, 8'd0,   1'b0, 1'b1, 1'b1, 1'b1, 8'd255, 1'b0, 8'd127, 1'b0, 8'd2, 8'd2);
        // broadcast blocked by lane 1, then released
        vecs[8]  = mk(2'd1, 8'h33,  1'b1, 1'b1, 1'b0, 1'b1, 8'd255, 1'b0, 8'h33,  1'b1, 8'd2, 8'd3);
        vecs[9]  = mk(2'd3, 8'hA5,  1'b1, 1'b1, 1'b0, 1'b0, 8'd255, 1'b0, 8'h33,  1'b1, 8'd2, 8'd3);
        vecs[10] = mk(2'd3, 8'hA5,  1'b1, 1'b1, 1'b1, 1'b1, 8'hA5,  1'b1, 8'hA5,  1'b1, 8'd3, 8'd4);
        // alternate 1,2,3,4 back to back
        vecs[11] = mk(2'd2, 8'd1,   1'b1, 1'b1, 1'b1, 1'b1, 8'd1,   1'b1, 8'hA5,  1'b0, 8'd4, 8'd4);
        vecs[12] = mk(2'd2, 8'd2,   1'b1, 1'b1, 1'b1, 1'b1, 8'd1,   1'b0, 8'd2,   1'b1, 8'd4, 8'd5);
        vecs[13] = mk(2'd2, 8'd3,   1'b1, 1'b1, 1'b1, 1'b1, 8'd3,   1'b1, 8'd2,   1'b0, 8'd5, 8'd5);
        vecs[14] = mk(2'd2, 8'd4,   1'b1, 1'b1, 1'b1, 1'b1, 8'd3,   1'b0, 8'd4,   1'b1, 8'd5, 8'd6);
        // lane-0 beat leaves alt at 0: next alt beat targets blocked lane 0
        vecs[15] = mk(2'd0, 8'd7,   1'b1, 1'b1, 1'b1, 1'b1, 8'd7,   1'b1, 8'd4,   1'b0, 8'd6, 8'd6);
        vecs[16] = mk(2'd2, 8'd8,   1'b1, 1'b0, 1'b1, 1'b0, 8'd7,   1'b1, 8'd4,   1'b0, 8'd6, 8'd6);
        // drain and load together keeps valid high; then alt steers to lane 1
        vecs[17] = mk(2'd2, 8'd8,   1'b1, 1'b1, 1'b1, 1'b1, 8'd8,   1'b1, 8'd4,   1'b0, 8'd7, 8'd6);
        vecs[18] = mk(2'd2, 8'd9,   1'b1, 1'b0, 1'b1, 1'b1, 8'd8,   1'b1, 8'd9,   1'b1, 8'd7, 8'd7);
        vecs[19] = mk(2'd0, 8'd0,   1'b0, 1'b1, 1'b1, 1'b1, 8'd8,   1'b0, 8'd9,   1'b0, 8'd7, 8'd7);

        drive(2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < int'(NVEC); i++) begin
            @(negedge clk);
            drive(vecs[i].s, vecs[i].d, vecs[i].v, vecs[i].r0, vecs[i].r1);
            #1;
            chk($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vecs[i].ir));
            @(posedge clk);
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].y0, vecs[i].y0v, vecs[i].y1, vecs[i].y1v,
                     vecs[i].c0, vecs[i].c1);
        end

        // counter wrap: fresh reset, 256 back-to-back beats into lane 0
        @(negedge clk);
        drive(2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            drive(2'd0, 8'(i + 1), 1'b1, 1'b1, 1'b0);
            @(posedge clk);
            #1;
            if (i == 254) chk("wrap.cnt0_255", 32'(bus.cnt0), 32'd255);
        end
        chk("wrap.cnt0_0",   32'(bus.cnt0),     32'd0);
        chk("wrap.y0_last",  32'(bus.y0),       32'd0);
        chk("wrap.y0_valid", 32'(bus.y0_valid), 32'd1);

        // async reset mid-cycle with lane 0 holding a beat
        @(negedge clk);
        drive(2'd1, 8'h5A, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("prerst.y1_valid", 32'(bus.y1_valid), 32'd1);
        chk("prerst.cnt1",     32'(bus.cnt1),     32'd1);
        drive(2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int sv = 0; sv < 4; sv++) begin
            bus.s = 2'(sv);
            #1;
            chk($sformatf("post_rst.in_ready_s%0d", sv), 32'(bus.in_ready), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
